imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Serial boot loader: assembles little-endian bytes into 32-bit words,
// writes them to instruction memory and releases the core when finished.
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte before the core is released (mismatch sets the sticky err flag).
module imem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        run,
    input  logic [5:0]  load_len,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [4:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LEN_W     = 6;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MAX_WORDS = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [LEN_W-1:0]    word_cnt;
    logic [LEN_W-1:0]    written_cnt;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          byte_cnt;
    logic [23:0]         word_buf;
    logic                accept;
    logic                start_ok;
    logic                last_byte;
    logic                more_words;
    logic [LEN_W-1:0]    len_clamped;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum;
    logic                err_q;
`endif

    // Handshake and session-control decodes shared by FSM and datapath
    always_comb begin
        accept      = byte_valid && byte_ready;
        start_ok    = start && ((state == IDLE) || (state == RUN));
        last_byte   = (byte_cnt == 2'd3);
        more_words  = (written_cnt + LEN_W'(1)) < word_cnt;
        len_clamped = ((load_len == '0) || (load_len > LEN_W'(MAX_WORDS)))
                      ? LEN_W'(MAX_WORDS) : load_len;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end else if (run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept && last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (more_words) begin
                    state_next = LOAD;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = RUN;
`endif
                end
            end
            CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    state_next = (byte_in == csum) ? RUN : IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Session counters, byte assembly and checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt    <= '0;
            written_cnt <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            word_buf    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum        <= '0;
            err_q       <= 1'b0;
`endif
        end else if (start_ok) begin
            word_cnt    <= len_clamped;
            written_cnt <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            word_buf    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            if ((state == LOAD) && accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    word_buf[7:0]   <= byte_in;
                    2'd1:    word_buf[15:8]  <= byte_in;
                    2'd2:    word_buf[23:16] <= byte_in;
                    default: word_buf        <= word_buf;
                endcase
`ifdef LOADER_CHECKSUM_EN
                csum <= csum ^ byte_in;
`endif
            end
            if (state == WRITE) begin
                word_idx    <= word_idx + ADDR_W'(1);
                written_cnt <= written_cnt + LEN_W'(1);
            end
`ifdef LOADER_CHECKSUM_EN
            if ((state == CHECK) && accept && (byte_in != csum)) begin
                err_q <= 1'b1;
            end
`endif
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            byte_ready <= (state_next == LOAD) || (state_next == CHECK);
            imem_we    <= (state_next == WRITE);
            imem_addr  <= (state_next == WRITE) ? word_idx : '0;
            imem_wdata <= (state_next == WRITE) ? {byte_in, word_buf} : DATA_W'(0);
            core_reset <= (state_next != RUN);
            busy       <= (state_next == LOAD) || (state_next == WRITE) ||
                          (state_next == CHECK);
            done       <= (state_next == RUN) &&
                          ((state == WRITE) || (state == CHECK));
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        run;
    logic [5:0]  load_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          ready_in_write = 0;
    logic [4:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  tb_csum;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .run        (run),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Log writes and done pulses mid-cycle
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            if (byte_ready) ready_in_write++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        ready_in_write = 0;
    endtask

    task automatic check_write(input int i, input logic [4:0] a, input logic [31:0] d);
        if (i < wr_addr.size()) begin
            check($sformatf("wr%0d_addr", i), 32'(wr_addr[i]), 32'(a));
            check($sformatf("wr%0d_data", i), wr_data[i], d);
        end else begin
            check($sformatf("wr%0d_missing", i), 32'(wr_addr.size()), 32'(i + 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (!byte_ready) check("send_timeout", 32'(byte_ready), 32'd1);
        else tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            tb_csum = tb_csum ^ w[8*k +: 8];
        end
    endtask

    task automatic begin_load(input logic [5:0] len);
        load_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tb_csum  = 8'h00;
    endtask

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_csum);
`endif
        byte_valid = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; run = 1'b0; load_len = '0;
        byte_in = '0; byte_valid = 1'b0; tb_csum = '0;
        tick(); tick(); tick();

        // Reset values
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_imem_addr",  32'(imem_addr),  32'd0);
        check("rst_imem_wdata", imem_wdata,      32'd0);
        reset = 1'b0;
        tick();
        clear_log();

        // Release the core with run only
        run = 1'b1;
        tick();
        run = 1'b0;
        check("run_core_reset", 32'(core_reset), 32'd0);
        check("run_busy",       32'(busy),       32'd0);
        tick(); tick();
        check("run_done_cnt",   32'(done_cnt),   32'd0);
        check("run_writes",     32'(wr_addr.size()), 32'd0);

        // Two-word load started from RUN
        clear_log();
        begin_load(6'd2);
        check("l2_core_reset",  32'(core_reset), 32'd1);
        check("l2_busy",        32'(busy),       32'd1);
        check("l2_byte_ready",  32'(byte_ready), 32'd1);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        finish_load();
        wait_not_busy("l2_timeout");
        check("l2_writes",      32'(wr_addr.size()), 32'd2);
        check_write(0, 5'd0, 32'h0000_0013);
        check_write(1, 5'd1, 32'h0010_0093);
        check("l2_done_cnt",    32'(done_cnt),   32'd1);
        check("l2_core_reset_after", 32'(core_reset), 32'd0);
        check("l2_imem_we_idle", 32'(imem_we),   32'd0);

        // load_len=0 clamps to a full 32-word image
        clear_log();
        begin_load(6'd0);
        for (int w = 0; w < 32; w++) begin
            send_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        end
        finish_load();
        wait_not_busy("l32_timeout");
        check("l32_writes",     32'(wr_addr.size()), 32'd32);
        for (int w = 0; w < 32; w++) begin
            check_write(w, 5'(w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        end
        check("l32_done_cnt",   32'(done_cnt),   32'd1);
        check("l32_core_reset", 32'(core_reset), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte
        clear_log();
        begin_load(6'd1);
        send_word(32'h0000_0013);
        send_byte(8'h00);
        byte_valid = 1'b0;
        wait_not_busy("cs_timeout");
        check("cs_err",         32'(err),        32'd1);
        check("cs_done_cnt",    32'(done_cnt),   32'd0);
        check("cs_core_reset",  32'(core_reset), 32'd1);
        check("cs_byte_ready",  32'(byte_ready), 32'd0);
        check("cs_writes",      32'(wr_addr.size()), 32'd1);
`endif

        // Reset in the middle of a word
        clear_log();
        begin_load(6'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_byte_ready", 32'(byte_ready), 32'd0);
        check("mid_busy",       32'(busy),       32'd0);
        check("mid_core_reset", 32'(core_reset), 32'd1);
        check("mid_err",        32'(err),        32'd0);
        tick(); tick();
        check("mid_writes",     32'(wr_addr.size()), 32'd0);
        begin_load(6'd1);
        send_word(32'hDDCC_BBAA);
        finish_load();
        wait_not_busy("fresh_timeout");
        check("fresh_writes",   32'(wr_addr.size()), 32'd1);
        check_write(0, 5'd0, 32'hDDCC_BBAA);
        check("fresh_core_reset", 32'(core_reset), 32'd0);

        // byte_valid toggling every other cycle
        clear_log();
        begin_load(6'd1);
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1'b0;
            tick();
            send_byte(8'(8'h11 * (k + 1)));
            tb_csum = tb_csum ^ 8'(8'h11 * (k + 1));
        end
`ifdef LOADER_CHECKSUM_EN
        byte_valid = 1'b0;
        tick();
`endif
        finish_load();
        wait_not_busy("tog_timeout");
        check("tog_writes",     32'(wr_addr.size()), 32'd1);
        check_write(0, 5'd0, 32'h4433_2211);
        check("tog_ready_in_write", 32'(ready_in_write), 32'd0);
        check("tog_done_cnt",   32'(done_cnt),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
